inst_fetch_queue: RTL
=====================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction queue between the fetch stage and decode. Fetch returns one 64-bit SRAM word per cycle, two
//  instructions at an 8-byte aligned pc. This block unpacks that word into a circular queue of {pc, inst} entries
//  and presents the two oldest entries to decode, which consumes 0..2 per cycle. It also back-pressures fetch,
//  drops discarded and flushed fetches, and handles fetches that start at an odd word (pc[2]=1).
// PARAMETERS
//  DEPTH   16   entries; power of two, >= 8
//  AW      4    log2(DEPTH); count register is AW+1 bits
// PORTS
//  clk          in   1    clock
//  rst          in   1    reset, synchronous, active-high
//  flush        in   1    exception/eret flush; empties queue
//  in_valid     in   1    fetch response valid this cycle (fetch enable delayed one cycle)
//  in_discard   in   1    branch resolved; drop this response
//  in_pc        in   32   exact pc of the first wanted instruction (bits[1:0]=0)
//  in_rdata     in   64   [31:0]=inst @ {in_pc[31:3],3'b000}; [63:32]=inst @ +4
//  issue_cnt    in   2    entries decode consumes this cycle: 0,1,2 (3 is treated as 2)
//  fetch_stall  out  1    to stall bus: stop issuing new fetches
//  out_valid0   out  1    head entry valid
//  out_pc0      out  32   head pc
//  out_inst0    out  32   head instruction
//  out_valid1   out  1    second entry valid
//  out_pc1      out  32   second pc
//  out_inst1    out  32   second instruction
//  ovf_err      out  1    sticky: a push was refused for lack of space
// BEHAVIOUR
//  Reset: rd_ptr=wr_ptr=0, count=0; all out_valid*=0; fetch_stall=0; ovf_err=0. Pc/inst outputs don't-care when invalid.
//  Push when in_valid & ~in_discard & ~flush:
//   - in_pc[2]=0: push 2 entries in order: {in_pc, rdata[31:0]}, then {in_pc+4, rdata[63:32]}.
//   - in_pc[2]=1: push 1 entry: {in_pc, rdata[63:32]}.
//  Pop: pop_n = min(issue_cnt clamped to 2, number of valid outputs). Entries are removed at posedge.
//  Next count = count + push_n - pop_n. Push and pop in the same cycle are both legal.
//   - Space check uses the post-pop count.
//  Pointers: wrap modulo DEPTH. Entry 1 of a pair goes to wr_ptr+1 mod DEPTH, so a pair may straddle the wrap.
//  Outputs: first-word fall-through from storage.
//   - out_valid0 = count>=1; out_valid1 = count>=2.
//   - Slot 1 reads rd_ptr+1 mod DEPTH.
//  Latency: a pushed entry is visible on out_* the cycle after the push (see bypass below).
//  fetch_stall: registered, = (next count >= DEPTH-4).
//   - The margin covers the fetch already in flight when the stall takes effect.
//  Overflow: if push_n > DEPTH - (count - pop_n), the whole response is dropped and ovf_err is set. ovf_err clears only on rst.
//  Flush: at the next edge, count=0, rd_ptr=wr_ptr=0, fetch_stall=0.
//   - Flush overrides a same-cycle push and pop. out_valid* read 0 the cycle after flush.
//  in_discard while in_valid=0: ignored. in_rdata and in_pc are don't-care when not pushing.
//  rst mid-operation: same as flush, and also clears ovf_err.
// CONFIGURATION
//  INST_FETCH_QUEUE_BYPASS_EN defined: when count==0 and a push occurs, the incoming entries drive out_* in the same cycle.
//   - Bypass output mapping: in_pc[2]=0 gives out_valid0=out_valid1=1; in_pc[2]=1 gives only out_valid0=1.
//   - Bypassed entries popped by issue_cnt are not written. The remainder is written at wr_ptr.
//   - count updates by the remainder only. Flush still overrides.
//   - This adds a combinational path in_rdata->out_inst*.
//  INST_FETCH_QUEUE_BYPASS_EN undefined: no bypass; out_* come from storage only, with the 1-cycle latency above.
// TESTING
//  1. After rst: push pc=0xbfc00000, rdata={0x2,0x1}, issue_cnt=0 -> next cycle count=2; out0={bfc00000,1}; out1={bfc00004,2}.
//  2. Odd start: push pc=0xbfc00014, rdata={0xB,0xA} on empty queue -> one entry {bfc00014,0xB}; out_valid1=0.
//  3. Fill: push pairs, issue_cnt=0, DEPTH=16 -> fetch_stall=1 the edge count reaches 12.
//     - An in-flight pair brings count to 14. A further forced push at 16 sets ovf_err=1 and leaves count=16.
//  4. Wrap: with rd_ptr=wr_ptr=15, push a pair -> entries land in slots 15 and 0. Pop 2 -> pcs come out in order and count=0.
//  5. Discard/flush: in_valid=1,in_discard=1 -> no push. Flush with count=7, a push and issue_cnt=2 in the same cycle
//     -> next cycle count=0, out_valid0=0, fetch_stall=0.
//  6. Simultaneous: count=1, push pair, issue_cnt=2 -> pop_n=1, next count=2, head=pushed pc.
//     - With BYPASS_EN and count=0: push pair with issue_cnt=2 -> both issued the same cycle; count stays 0.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: unpacks 64-bit fetch words into a {pc, inst} circular queue feeding two decode slots.
// Optional INST_FETCH_QUEUE_BYPASS_EN: a push into an empty queue drives out_* in the same cycle.
module inst_fetch_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_discard,
    input  logic [31:0] in_pc,
    input  logic [63:0] in_rdata,
    input  logic [1:0]  issue_cnt,
    output logic        fetch_stall,
    output logic        out_valid0,
    output logic [31:0] out_pc0,
    output logic [31:0] out_inst0,
    output logic        out_valid1,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst1,
    output logic        ovf_err
);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_AT = (AW+1)'(DEPTH - 4);
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
    logic [AW:0]   count, post_pop, next_count;
    logic          push_req, push_ok, bypass;
    logic [1:0]    push_n, issue, avail, pop_n, pop_q, wr_n;
    logic [31:0]   e0_pc, e0_inst, e1_pc, e1_inst, w0_pc, w0_inst;

    assign rd_ptr1  = rd_ptr + 1'b1;
    assign wr_ptr1  = wr_ptr + 1'b1;
    assign push_req = in_valid & ~in_discard & ~flush;
    assign push_n   = push_req ? (in_pc[2] ? 2'd1 : 2'd2) : 2'd0;
    assign issue    = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
    assign e0_pc    = in_pc;
    assign e0_inst  = in_pc[2] ? in_rdata[63:32] : in_rdata[31:0];
    assign e1_pc    = in_pc + 32'd4;
    assign e1_inst  = in_rdata[63:32];
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    assign bypass   = push_req && count == '0;
`else
    assign bypass   = 1'b0;
`endif

    // Pop accounting, space check and what actually lands in storage this cycle
    always_comb begin
        avail      = bypass ? push_n : (count >= (AW+1)'(2) ? 2'd2 : count[1:0]);
        pop_n      = (issue < avail) ? issue : avail;
        pop_q      = bypass ? 2'd0 : pop_n;
        post_pop   = count - (AW+1)'(pop_q);
        push_ok    = bypass | ((AW+1)'(push_n) <= FULL - post_pop);
        wr_n       = bypass ? push_n - pop_n : (push_ok ? push_n : 2'd0);
        w0_pc      = (bypass && pop_n == 2'd1) ? e1_pc : e0_pc;
        w0_inst    = (bypass && pop_n == 2'd1) ? e1_inst : e0_inst;
        next_count = post_pop + (AW+1)'(wr_n);
    end

    // Decode slots: fall-through from storage, or straight from the fetch word when bypassing
    always_comb begin
        out_valid0 = bypass | (count != '0);
        out_pc0    = bypass ? e0_pc : pc_mem[rd_ptr];
        out_inst0  = bypass ? e0_inst : inst_mem[rd_ptr];
        out_valid1 = bypass ? (push_n == 2'd2) : (count >= (AW+1)'(2));
        out_pc1    = bypass ? e1_pc : pc_mem[rd_ptr1];
        out_inst1  = bypass ? e1_inst : inst_mem[rd_ptr1];
    end

    // Entry storage; the second entry of a pair may wrap to slot 0
    always_ff @(posedge clk) begin
        if (wr_n != 2'd0) begin
            pc_mem[wr_ptr]   <= w0_pc;
            inst_mem[wr_ptr] <= w0_inst;
        end
        if (wr_n == 2'd2) begin
            pc_mem[wr_ptr1]   <= e1_pc;
            inst_mem[wr_ptr1] <= e1_inst;
        end
    end

    // Pointers, occupancy, registered stall and sticky overflow
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_stall <= 1'b0;
            if (rst) ovf_err <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr + AW'(pop_q);
            wr_ptr      <= wr_ptr + AW'(wr_n);
            count       <= next_count;
            fetch_stall <= next_count >= STALL_AT;
            if (push_req && !push_ok) ovf_err <= 1'b1;
        end
    end
endmodule
